// File: rtl/sha3_pkg.sv
// Shared Keccak state types and the lane-ordering helper used by every
// block that consumes a full 5x5 state.
package sha3_pkg;

  localparam int STATE_LANES = 25;
  localparam int SLICE_LANES = 5;

  typedef logic [63:0] lane_t;

  // One input slice carries five 64-bit lanes; component c sits at [c].
  typedef lane_t [SLICE_LANES-1:0] slice_t;

  // Full state, lane k at index k. Kept packed so it can be passed through
  // ports and returned from functions without unpacked-array restrictions.
  typedef lane_t [STATE_LANES-1:0] state_t;

  // Serializer control states: IDLE has no state to stream, SEND does.
  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_e;

  // Where the ACTIVE buffer is (re)loaded from on a given cycle.
  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_INPUT,
    LOAD_PENDING
  } load_src_e;

  // Lane k = slice k/5 (a..e), component k%5. With the packed layout this
  // is a plain concatenation: slice a fills lanes 0..4, slice e lanes 20..24.
  function automatic state_t flatten(input slice_t sa, input slice_t sb,
                                     input slice_t sc, input slice_t sd,
                                     input slice_t se);
    state_t st;
    st = {se, sd, sc, sb, sa};
    return st;
  endfunction

endpackage

// File: rtl/sha3_state_capture.sv
// Single full-state holding register with a valid flag. Used as the PENDING
// buffer of the serializer: loaded on 'sample', emptied on 'release_buf'.
module sha3_state_capture
  import sha3_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   sample,
  input  logic   release_buf,
  input  state_t state_in,
  output state_t state_out,
  output logic   valid
);

  state_t data_q;
  logic   valid_q;

  // Valid flag: a same-cycle sample wins over a release so a hand-over
  // that refills the buffer never loses the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (sample) begin
      valid_q <= 1'b1;
    end else if (release_buf) begin
      valid_q <= 1'b0;
    end
  end

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (sample) begin
      data_q <= state_in;
    end
  end

  assign state_out = data_q;
  assign valid     = valid_q;

endmodule

// File: rtl/sha3_state_serializer.sv
// Streams a 25-lane Keccak state out as 64-bit words over valid/ready.
// ACTIVE buffer (being streamed) plus a PENDING buffer so a second result
// arriving mid-stream is absorbed and follows with no idle cycle.
module sha3_state_serializer
  import sha3_pkg::*;
#(
  parameter int OUT_WORDS = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               good,
  input  logic [4:0][63:0]   isa,
  input  logic [4:0][63:0]   isb,
  input  logic [4:0][63:0]   isc,
  input  logic [4:0][63:0]   isd,
  input  logic [4:0][63:0]   ise,
  output logic               iready,
  output logic               ovalid,
  input  logic               oready,
  output logic [63:0]        oword,
  output logic [4:0]         oidx,
  output logic               olast,
  output logic               overflow
);

  if (OUT_WORDS < 1 || OUT_WORDS > STATE_LANES) begin : g_bad_out_words
    $error("sha3_state_serializer: OUT_WORDS=%0d outside 1..25", OUT_WORDS);
  end

  localparam logic [4:0] LAST_IDX = 5'(OUT_WORDS - 1);

  ser_state_e state_q;
  ser_state_e state_d;
  logic [4:0] idx_q;
  logic [4:0] idx_d;
  load_src_e  load_src;
  logic       advance;
  logic       xfer;
  logic       final_xfer;
  logic       accept_pend;
  logic       release_pend;
  logic       drop;

  state_t     in_state;
  state_t     active_q;
  state_t     pend_state;
  logic       pend_valid;
  lane_t      word_q;
  logic       overflow_q;

  assign in_state = flatten(isa, isb, isc, isd, ise);

  sha3_state_capture u_pending (
    .clk         (clk),
    .rst         (rst),
    .sample      (accept_pend),
    .release_buf (release_pend),
    .state_in    (in_state),
    .state_out   (pend_state),
    .valid       (pend_valid)
  );

  // FSM and lane counter registers; reset abandons anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state decode: advance on transfer, reload on the final lane from
  // PENDING first, then from a same-cycle input, otherwise fall idle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_src     = LOAD_NONE;
    advance      = 1'b0;
    accept_pend  = 1'b0;
    release_pend = 1'b0;
    drop         = 1'b0;
    xfer         = (state_q == ST_SEND) && oready;
    final_xfer   = xfer && (idx_q == LAST_IDX);
    case (state_q)
      ST_IDLE: begin
        if (good) begin
          load_src = LOAD_INPUT;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (final_xfer) begin
          if (pend_valid) begin
            load_src     = LOAD_PENDING;
            idx_d        = '0;
            release_pend = 1'b1;
            accept_pend  = good;
          end else if (good) begin
            load_src = LOAD_INPUT;
            idx_d    = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d   = idx_q + 5'd1;
            advance = 1'b1;
          end
          if (good) begin
            if (pend_valid) begin
              drop = 1'b1;
            end else begin
              accept_pend = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ACTIVE buffer contents; only read while streaming, so no reset needed.
  always_ff @(posedge clk) begin
    case (load_src)
      LOAD_INPUT:   active_q <= in_state;
      LOAD_PENDING: active_q <= pend_state;
      default:      active_q <= active_q;
    endcase
  end

  // Registered output word: lane 0 of the incoming state on a load,
  // otherwise the next lane of ACTIVE selected by the new counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      case (load_src)
        LOAD_INPUT:   word_q <= in_state[0];
        LOAD_PENDING: word_q <= pend_state[0];
        default: begin
          if (advance) begin
            word_q <= active_q[idx_d];
          end
        end
      endcase
    end
  end

  // Sticky record that a result was discarded for lack of buffer space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign ovalid   = (state_q == ST_SEND);
  assign oword    = word_q;
  assign oidx     = idx_q;
  assign olast    = ovalid && (idx_q == LAST_IDX);
  assign iready   = !pend_valid;
  assign overflow = overflow_q;

endmodule
